// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a chained-PE systolic MAC array: clear, activation load, weight stream, drain.
// Optional macro SYSTOLIC_SEQ_ABORT_EN adds an abort input that cancels a job in flight.
module systolic_seq_ctrl #(
    parameter int MAC_NUM  = 10,
    parameter int ACCU_NUM = 5,
    parameter int PIPE_LAT = ACCU_NUM + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [7:0]                  cfg_shift,
`ifdef SYSTOLIC_SEQ_ABORT_EN
    input  logic                        abort,
`endif
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic                        wet_valid,
    output logic                        wet_ready,
    output logic                        pe_clear_acc,
    output logic                        pe_mac_enable,
    output logic                        pe_act_we,
    output logic [$clog2(ACCU_NUM)-1:0] pe_act_idx,
    output logic                        pe_wet_strobe,
    output logic [7:0]                  pe_res_shift_num,
    output logic                        res_capture,
    output logic [$clog2(MAC_NUM)-1:0]  res_idx,
    output logic                        busy,
    output logic                        done
);
    localparam int AIW = $clog2(ACCU_NUM);
    localparam int RIW = $clog2(MAC_NUM);
    localparam logic [AIW-1:0] ACT_LAST = AIW'(ACCU_NUM - 1);
    localparam logic [RIW-1:0] RES_LAST = RIW'(MAC_NUM - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_ACT, STREAM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [AIW-1:0]        act_cnt_q, act_cnt_d, act_idx_q, act_idx_d;
    logic [RIW-1:0]        wet_cnt_q, wet_cnt_d, res_idx_q, res_idx_d;
    logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
    logic [7:0]            shift_q, shift_d;
    logic act_rdy_q, act_rdy_d, wet_rdy_q, wet_rdy_d, clr_q, clr_d, mac_q, mac_d;
    logic act_we_q, act_we_d, strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
    logic act_acc, wet_acc;

    assign act_acc = act_valid & act_rdy_q;
    assign wet_acc = wet_valid & wet_rdy_q;

    always_comb begin
        state_d   = state_q;
        act_cnt_d = act_cnt_q;
        wet_cnt_d = wet_cnt_q;
        act_idx_d = act_idx_q;
        res_idx_d = res_idx_q;
        shift_d   = shift_q;
        act_we_d  = 1'b0;
        strobe_d  = 1'b0;
        // Valid pipe mirrors the array latency and never stalls.
        pipe_d    = {pipe_q[PIPE_LAT-1:0], strobe_q} >> 0;
        for (int i = PIPE_LAT - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
        pipe_d[0] = strobe_q;
        if (pipe_q[PIPE_LAT-1] && res_idx_q != RES_LAST) res_idx_d = res_idx_q + 1'b1;
        case (state_q)
            IDLE: if (start) begin
                shift_d   = cfg_shift;
                act_cnt_d = '0;
                wet_cnt_d = '0;
                res_idx_d = '0;
                state_d   = CLEAR;
            end
            CLEAR: state_d = LOAD_ACT;
            LOAD_ACT: if (act_acc) begin
                act_we_d  = 1'b1;
                act_idx_d = act_cnt_q;
                if (act_cnt_q == ACT_LAST) state_d = STREAM;
                else act_cnt_d = act_cnt_q + 1'b1;
            end
            STREAM: if (wet_acc) begin
                strobe_d = 1'b1;
                if (wet_cnt_q == RES_LAST) state_d = DRAIN;
                else wet_cnt_d = wet_cnt_q + 1'b1;
            end
            DRAIN: if (pipe_q[PIPE_LAT-1] && res_idx_q == RES_LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_d = (state_d == CLEAR);
`ifdef SYSTOLIC_SEQ_ABORT_EN
        // Abort flushes the job and leaves a clear pulse so the array starts clean.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            act_cnt_d = '0;
            wet_cnt_d = '0;
            act_idx_d = '0;
            res_idx_d = '0;
            pipe_d    = '0;
            act_we_d  = 1'b0;
            strobe_d  = 1'b0;
            clr_d     = 1'b1;
        end
`endif
        mac_d     = strobe_d | (state_d == DRAIN);
        act_rdy_d = (state_d == LOAD_ACT);
        wet_rdy_d = (state_d == STREAM);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            act_cnt_q <= '0;
            wet_cnt_q <= '0;
            act_idx_q <= '0;
            res_idx_q <= '0;
            pipe_q    <= '0;
            shift_q   <= '0;
            act_rdy_q <= 1'b0;
            wet_rdy_q <= 1'b0;
            clr_q     <= 1'b0;
            mac_q     <= 1'b0;
            act_we_q  <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_cnt_q <= act_cnt_d;
            wet_cnt_q <= wet_cnt_d;
            act_idx_q <= act_idx_d;
            res_idx_q <= res_idx_d;
            pipe_q    <= pipe_d;
            shift_q   <= shift_d;
            act_rdy_q <= act_rdy_d;
            wet_rdy_q <= wet_rdy_d;
            clr_q     <= clr_d;
            mac_q     <= mac_d;
            act_we_q  <= act_we_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign act_ready        = act_rdy_q;
    assign wet_ready        = wet_rdy_q;
    assign pe_clear_acc     = clr_q;
    assign pe_mac_enable    = mac_q;
    assign pe_act_we        = act_we_q;
    assign pe_act_idx       = act_idx_q;
    assign pe_wet_strobe    = strobe_q;
    assign pe_res_shift_num = shift_q;
    assign res_capture      = pipe_q[PIPE_LAT-1];
    assign res_idx          = res_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: per-job timeline model built from valid patterns.
module tb_systolic_seq_ctrl;
    localparam int ACC = 5;
    localparam int MAC = 10;
    localparam int LAT = ACC + 1;
    localparam int N   = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_shift = 8'h00;
    logic       act_valid = 1'b0;
    logic       wet_valid = 1'b0;
`ifdef SYSTOLIC_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       act_ready, wet_ready, pe_clear_acc, pe_mac_enable, pe_act_we;
    logic [2:0] pe_act_idx;
    logic       pe_wet_strobe, res_capture, busy, done;
    logic [7:0] pe_res_shift_num;
    logic [3:0] res_idx;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_shift = 8'h00;

    systolic_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_shift(cfg_shift),
`ifdef SYSTOLIC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .act_valid(act_valid), .act_ready(act_ready),
        .wet_valid(wet_valid), .wet_ready(wet_ready),
        .pe_clear_acc(pe_clear_acc), .pe_mac_enable(pe_mac_enable),
        .pe_act_we(pe_act_we), .pe_act_idx(pe_act_idx),
        .pe_wet_strobe(pe_wet_strobe), .pe_res_shift_num(pe_res_shift_num),
        .res_capture(res_capture), .res_idx(res_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // mode 0: always valid; 1: random valids plus stray starts; 2: 3-cycle weight stall after weight 4
    task automatic run_job(input logic [7:0] cfg, input int mode, input int rst_at, input int abort_at);
        logic av[N], wv[N], st[N];
        logic [7:0] cf[N];
        int e_ar[N], e_wr[N], e_cl[N], e_mac[N], e_we[N], e_ai[N], e_str[N];
        int e_cap[N], e_ri[N], e_busy[N], e_done[N], e_sh[N];
        int s, cnt, lastA, lastW, lastCap, cut;
        s = 2;
        cut = (rst_at >= 0) ? rst_at : ((abort_at >= 0) ? abort_at : N);
        for (int k = 0; k < N; k++) begin
            av[k] = (mode == 1) ? ((k >= 60) || ($urandom_range(0, 3) != 0)) : 1'b1;
            wv[k] = (mode == 1) ? ((k >= 60) || ($urandom_range(0, 3) != 0)) : 1'b1;
            st[k] = (k == s);
            cf[k] = (k == s) ? cfg : 8'($urandom);
            e_ar[k] = 0; e_wr[k] = 0; e_cl[k] = 0; e_mac[k] = 0; e_we[k] = 0; e_ai[k] = 0;
            e_str[k] = 0; e_cap[k] = 0; e_ri[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_sh[k] = (k >= s) ? int'(cfg) : int'(prev_shift);
        end
        cnt = 0; lastA = N;
        for (int k = s + 2; k < N && cnt < ACC; k++)
            if (av[k]) begin
                e_we[k] = 1; e_ai[k] = cnt; cnt++;
                if (cnt == ACC) lastA = k;
            end
        if (mode == 2)
            for (int k = lastA + 5; k <= lastA + 7; k++) wv[k] = 1'b0;
        cnt = 0; lastW = N;
        for (int k = lastA + 1; k < N && cnt < MAC; k++)
            if (wv[k]) begin
                e_str[k] = 1; e_mac[k] = 1;
                if (k + LAT < N) begin e_cap[k + LAT] = 1; e_ri[k + LAT] = cnt; end
                cnt++;
                if (cnt == MAC) lastW = k;
            end
        lastCap = lastW + LAT;
        for (int k = 0; k < N; k++) begin
            if (k >= s + 1 && k < lastA) e_ar[k] = 1;
            if (k >= lastA && k < lastW) e_wr[k] = 1;
            if (k >= lastW && k <= lastCap) e_mac[k] = 1;
            if (k >= s && k <= lastCap + 1) e_busy[k] = 1;
            e_done[k] = (k == lastCap + 1);
            e_cl[k] = (k == s);
        end
        if (mode == 1)
            for (int k = s + 1; k <= lastCap + 1 && k < N; k++)
                if ($urandom_range(0, 4) == 0) begin st[k] = 1'b1; cf[k] = 8'h03; end
        for (int k = cut; k < N; k++) begin
            st[k] = 1'b0;
            e_ar[k] = 0; e_wr[k] = 0; e_mac[k] = 0; e_we[k] = 0; e_ai[k] = 0; e_str[k] = 0;
            e_cap[k] = 0; e_ri[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_cl[k] = (k == abort_at);
            e_sh[k] = (rst_at >= 0) ? 0 : int'(cfg);
        end
        for (int k = 0; k < N; k++) begin
            start = st[k]; cfg_shift = cf[k]; act_valid = av[k]; wet_valid = wv[k];
            reset_n = (k != rst_at);
`ifdef SYSTOLIC_SEQ_ABORT_EN
            abort = (k == abort_at);
`endif
            @(posedge clk); #1;
            chk("act_ready", k, 32'(act_ready), e_ar[k]);
            chk("wet_ready", k, 32'(wet_ready), e_wr[k]);
            chk("clear_acc", k, 32'(pe_clear_acc), e_cl[k]);
            chk("mac_enable", k, 32'(pe_mac_enable), e_mac[k]);
            chk("act_we", k, 32'(pe_act_we), e_we[k]);
            chk("wet_strobe", k, 32'(pe_wet_strobe), e_str[k]);
            chk("res_capture", k, 32'(res_capture), e_cap[k]);
            chk("busy", k, 32'(busy), e_busy[k]);
            chk("done", k, 32'(done), e_done[k]);
            chk("shift_num", k, 32'(pe_res_shift_num), e_sh[k]);
            if (e_we[k] != 0 || k >= cut) chk("act_idx", k, 32'(pe_act_idx), e_ai[k]);
            if (e_cap[k] != 0 || k >= cut) chk("res_idx", k, 32'(res_idx), e_ri[k]);
        end
        start = 1'b0; reset_n = 1'b1;
`ifdef SYSTOLIC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        prev_shift = 8'(e_sh[N-1]);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_act_ready", 0, 32'(act_ready), 0);
        chk("rst_wet_ready", 0, 32'(wet_ready), 0);
        chk("rst_capture", 0, 32'(res_capture), 0);
        chk("rst_shift", 0, 32'(pe_res_shift_num), 0);
        chk("rst_act_idx", 0, 32'(pe_act_idx), 0);
        chk("rst_res_idx", 0, 32'(res_idx), 0);
        reset_n = 1'b1;
        run_job(8'h5a, 0, -1, -1);
        run_job(8'h11, 2, -1, -1);
        run_job(8'h07, 1, -1, -1);
        for (int j = 0; j < 4; j++) run_job(8'($urandom), 1, -1, -1);
        run_job(8'h22, 0, 21, -1);
        run_job(8'h66, 0, -1, -1);
`ifdef SYSTOLIC_SEQ_ABORT_EN
        run_job(8'h33, 0, -1, 6);
        run_job(8'h44, 0, -1, -1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
